wisard_bleach: RTL and testbench

Next-generation WiSARD classifier core with a ready/valid handshake. It consumes LANES RAM addresses per beat and looks each one up in a generated counter LUT. Per-class scores are accumulated using a runtime bleaching threshold. The block then runs a sequential argmax that reports winner, best score, confidence margin and tie flag, holding the result until the downstream stage accepts it. It sits between the address encoder/hasher and the result sink.

---
 rtl/wisard_pkg.sv | 20 ++
 rtl/wisard_bleach_if.sv | 35 +++
 rtl/wisard_argmax.sv | 47 ++++
 rtl/wisard_lut.sv | 17 +
 rtl/wisard_bleach.sv | 127 ++++++++++++
 tb/tb_wisard_bleach.sv | 158 +++++++++++++++
 6 files changed

// File: rtl/wisard_pkg.sv
// rtl/wisard_pkg.sv - shared types and helpers for the WiSARD bleaching classifier
package wisard_pkg;

  typedef enum logic [1:0] {
    ST_ACCUM  = 2'd0,
    ST_SEARCH = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  localparam int LANE_BUS_MAX = 1024;

  function automatic int score_w(int index_width, int lanes);
    return index_width + $clog2(lanes) + 1;
  endfunction

  function automatic logic [31:0] lane_slice(logic [LANE_BUS_MAX-1:0] bus, int lane, int aw);
    return 32'(bus >> (lane * aw)) & ((32'd1 << aw) - 32'd1);
  endfunction

endpackage

// File: rtl/wisard_bleach_if.sv
// rtl/wisard_bleach_if.sv - beat sink and result source bundle of wisard_bleach
interface wisard_bleach_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int INDEX_WIDTH   = 6,
  parameter int LANES         = 2,
  parameter int CLASS_WIDTH   = 4,
  parameter int CNT_WIDTH     = 2
);
  import wisard_pkg::*;
  localparam int SCORE_W = score_w(INDEX_WIDTH, LANES);

  logic                           sink_valid;
  logic                           sink_ready;
  logic                           sop;
  logic                           eop;
  logic [INDEX_WIDTH-1:0]         index;
  logic [LANES*ADDRESS_WIDTH-1:0] addr;
  logic [CNT_WIDTH-1:0]           bleach;
  logic                           source_valid;
  logic                           source_ready;
  logic [CLASS_WIDTH-1:0]         class_result;
  logic [SCORE_W-1:0]             max_score;
  logic [SCORE_W-1:0]             margin;
  logic                           tie;

  modport master (
    output sink_valid, sop, eop, index, addr, bleach, source_ready,
    input  sink_ready, source_valid, class_result, max_score, margin, tie
  );

  modport slave (
    input  sink_valid, sop, eop, index, addr, bleach, source_ready,
    output sink_ready, source_valid, class_result, max_score, margin, tie
  );
endinterface

// File: rtl/wisard_argmax.sv
// rtl/wisard_argmax.sv - sequential best/second-best scan, one class per step
module wisard_argmax #(
  parameter int N_CLASSES   = 10,
  parameter int CLASS_WIDTH = 4,
  parameter int SW          = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_step,
  input  logic                   i_first,
  input  logic [CLASS_WIDTH-1:0] i_k,
  input  logic [SW-1:0]          i_score,
  output logic [CLASS_WIDTH-1:0] o_class,
  output logic [SW-1:0]          o_best,
  output logic [SW-1:0]          o_margin,
  output logic                   o_tie
);
  logic [SW-1:0]          r_best;
  logic [SW-1:0]          r_second;
  logic [CLASS_WIDTH-1:0] r_class;

  // strict > keeps the lowest index on ties; second starts at 0 since scores are unsigned
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_best   <= '0;
      r_second <= '0;
      r_class  <= '0;
    end else if (i_step) begin
      if (i_first) begin
        r_best   <= i_score;
        r_second <= '0;
        r_class  <= i_k;
      end else if (i_score > r_best) begin
        r_second <= r_best;
        r_best   <= i_score;
        r_class  <= i_k;
      end else if (i_score >= r_second) begin
        r_second <= i_score;
      end
    end
  end

  assign o_class  = r_class;
  assign o_best   = r_best;
  assign o_margin = r_best - r_second;
  assign o_tie    = (N_CLASSES > 1) ? (r_best == r_second) : 1'b0;
endmodule

// File: rtl/wisard_lut.sv
// rtl/wisard_lut.sv - generated RAM contents: per-class bleaching counters keyed by {beat slot, address}
module wisard_lut #(
  parameter int I_WIDTH   = 15,
  parameter int O_WIDTH   = 20,
  parameter int CNT_WIDTH = 2
) (
  input  logic [I_WIDTH-1:0] i_key,
  output logic [O_WIDTH-1:0] o_cnt
);
  localparam int N = O_WIDTH / CNT_WIDTH;

  for (genvar c = 0; c < N; c++) begin : g_cls
    logic [31:0] w_mix;
    assign w_mix = 32'(i_key) * 32'(2 * c + 1) + 32'(c);
    assign o_cnt[c*CNT_WIDTH +: CNT_WIDTH] = CNT_WIDTH'((w_mix ^ (w_mix >> 7)) >> 2);
  end
endmodule

// File: rtl/wisard_bleach.sv
// rtl/wisard_bleach.sv - WiSARD classifier: LUT lookup, bleached score accumulation, argmax, held result
module wisard_bleach
  import wisard_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 8,
  parameter int INDEX_WIDTH   = 6,
  parameter int LANES         = 2,
  parameter int N_CLASSES     = 10,
  parameter int CLASS_WIDTH   = 4,
  parameter int CNT_WIDTH     = 2
) (
  input  logic          clk,
  input  logic          rst,
  wisard_bleach_if.slave s
);
  localparam int SW = score_w(INDEX_WIDTH, LANES);
  localparam int BW = INDEX_WIDTH + $clog2(LANES);
  localparam int KW = ADDRESS_WIDTH + BW;
  localparam int OW = N_CLASSES * CNT_WIDTH;

  state_t                 r_state, w_next;
  logic [CLASS_WIDTH:0]   r_k;
  logic [SW-1:0]          r_score [N_CLASSES];
  logic [CNT_WIDTH-1:0]   r_bleach;
  logic [CLASS_WIDTH-1:0] r_class;
  logic [SW-1:0]          r_max, r_margin;
  logic                   r_tie;

  logic                   w_acc, w_last;
  logic [CNT_WIDTH-1:0]   w_thr;
  logic [OW-1:0]          w_cnt [LANES];
  logic [SW-1:0]          w_inc [N_CLASSES];
  logic [CLASS_WIDTH-1:0] w_kidx, w_am_class;
  logic [SW-1:0]          w_am_best, w_am_margin;
  logic                   w_am_tie;

  function automatic logic [SW-1:0] sat_add(logic [SW-1:0] a, logic [SW-1:0] b);
    logic [SW:0] t;
    t = {1'b0, a} + {1'b0, b};
    return t[SW] ? '1 : t[SW-1:0];
  endfunction

  assign s.sink_ready   = (r_state == ST_ACCUM);
  assign s.source_valid = (r_state == ST_HOLD);
  assign w_acc  = s.sink_valid & s.sink_ready;
  assign w_thr  = s.sop ? s.bleach : r_bleach;
  assign w_last = (r_k == (CLASS_WIDTH + 1)'(N_CLASSES));
  assign w_kidx = w_last ? '0 : r_k[CLASS_WIDTH-1:0];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [BW-1:0] w_beat;
    assign w_beat = BW'(s.index) * BW'(LANES) + BW'(l);
    wisard_lut #(.I_WIDTH(KW), .O_WIDTH(OW), .CNT_WIDTH(CNT_WIDTH)) u_lut (
      .i_key({w_beat, ADDRESS_WIDTH'(lane_slice(LANE_BUS_MAX'(s.addr), l, ADDRESS_WIDTH))}),
      .o_cnt(w_cnt[l])
    );
  end

  always_comb begin
    for (int c = 0; c < N_CLASSES; c++) begin
      w_inc[c] = '0;
      for (int l = 0; l < LANES; l++) begin
        if (w_cnt[l][c*CNT_WIDTH +: CNT_WIDTH] > w_thr) w_inc[c] = w_inc[c] + SW'(1);
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_ACCUM:  if (w_acc && s.eop) w_next = ST_SEARCH;
      ST_SEARCH: if (w_last) w_next = ST_HOLD;
      ST_HOLD:   if (s.source_ready) w_next = ST_ACCUM;
      default:   w_next = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_ACCUM;
    else     r_state <= w_next;
  end

  // r_k runs one past the last class so the finished scan is captured a cycle later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < N_CLASSES; c++) r_score[c] <= '0;
      r_bleach <= '0;
      r_k      <= '0;
      r_class  <= '0;
      r_max    <= '0;
      r_margin <= '0;
      r_tie    <= 1'b0;
    end else begin
      if (w_acc) begin
        if (s.sop) r_bleach <= s.bleach;
        for (int c = 0; c < N_CLASSES; c++)
          r_score[c] <= s.sop ? w_inc[c] : sat_add(r_score[c], w_inc[c]);
      end
      if (r_state == ST_ACCUM)       r_k <= '0;
      else if (r_state == ST_SEARCH) r_k <= r_k + 1'b1;
      if (r_state == ST_SEARCH && w_last) begin
        r_class  <= w_am_class;
        r_max    <= w_am_best;
        r_margin <= w_am_margin;
        r_tie    <= w_am_tie;
      end
    end
  end

  wisard_argmax #(.N_CLASSES(N_CLASSES), .CLASS_WIDTH(CLASS_WIDTH), .SW(SW)) u_argmax (
    .clk      (clk),
    .rst      (rst),
    .i_step   ((r_state == ST_SEARCH) && !w_last),
    .i_first  (r_k == '0),
    .i_k      (w_kidx),
    .i_score  (r_score[w_kidx]),
    .o_class  (w_am_class),
    .o_best   (w_am_best),
    .o_margin (w_am_margin),
    .o_tie    (w_am_tie)
  );

  assign s.class_result = r_class;
  assign s.max_score    = r_max;
  assign s.margin       = r_margin;
  assign s.tie          = r_tie;
endmodule

// File: tb/tb_wisard_bleach.sv
// tb/tb_wisard_bleach.sv - randomized self-checking bench for wisard_bleach against a score-level model
module tb_wisard_bleach;
  localparam int AW = 8, IW = 6, LN = 2, NC = 4, CW = 2, CN = 2;
  localparam int SW = IW + $clog2(LN) + 1;
  localparam int SMAX = (1 << SW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wisard_bleach_if #(.ADDRESS_WIDTH(AW), .INDEX_WIDTH(IW), .LANES(LN),
                     .CLASS_WIDTH(CW), .CNT_WIDTH(CN)) bus ();

  wisard_bleach #(.ADDRESS_WIDTH(AW), .INDEX_WIDTH(IW), .LANES(LN), .N_CLASSES(NC),
                  .CLASS_WIDTH(CW), .CNT_WIDTH(CN)) dut (
    .clk (clk),
    .rst (rst),
    .s   (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int mdl_score [NC];
  int mdl_bleach;

  task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int lut(int key, int c);
    int unsigned m;
    m = key * (2 * c + 1) + c;
    m = m ^ (m >> 7);
    return (m >> 2) & 3;
  endfunction

  task automatic model_beat(bit sop, int idx, int a, int bl);
    int thr, inc, key;
    thr = sop ? bl : mdl_bleach;
    if (sop) mdl_bleach = bl;
    for (int c = 0; c < NC; c++) begin
      inc = 0;
      for (int l = 0; l < LN; l++) begin
        key = ((idx * LN + l) << AW) | ((a >> (l * AW)) & 255);
        if (lut(key, c) > thr) inc++;
      end
      mdl_score[c] = sop ? inc : ((mdl_score[c] + inc > SMAX) ? SMAX : mdl_score[c] + inc);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NC; c++) mdl_score[c] = 0;
    mdl_bleach = 0;
  endtask

  task automatic drive_beat(bit sop, bit eop, int idx, int a, int bl);
    bus.sink_valid = 1'b1;
    bus.sop        = sop;
    bus.eop        = eop;
    bus.index      = IW'(idx);
    bus.addr       = 16'(a);
    bus.bleach     = CN'(bl);
    check("beat_ready", bus.sink_ready, 1);
    @(posedge clk); #1;
    bus.sink_valid = 1'b0;
    bus.sop        = 1'b0;
    bus.eop        = 1'b0;
    model_beat(sop, idx, a & 16'hffff, bl);
  endtask

  task automatic run_sample(int nb, bit use_sop, int bl, int restart, int hold);
    int cnt, best, cls, sec, word;
    bus.source_ready = (hold == 0);
    for (int b = 0; b < nb; b++) begin
      bit sop;
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      sop = (use_sop && b == 0) || (b == restart);
      drive_beat(sop, b == nb - 1, b % 64, int'($urandom), sop ? bl : int'($urandom_range(0, 3)));
    end
    check("busy_after_eop", bus.sink_ready, 0);
    cnt = 0;
    while (!bus.source_valid && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("latency", cnt, NC + 1);

    best = -1; cls = 0; sec = 0;
    for (int c = 0; c < NC; c++) if (mdl_score[c] > best) begin best = mdl_score[c]; cls = c; end
    for (int c = 0; c < NC; c++) if (c != cls && mdl_score[c] > sec) sec = mdl_score[c];
    check("class_result", bus.class_result, cls);
    check("max_score", bus.max_score, best);
    check("margin", bus.margin, best - sec);
    check("tie", bus.tie, (best == sec) ? 1 : 0);
    word = (cls << (2 * SW + 1)) | (best << (SW + 1)) | ((best - sec) << 1) | ((best == sec) ? 1 : 0);

    for (int i = 0; i < hold; i++) begin
      if (i == hold / 2) begin
        bus.sink_valid = 1'b1; bus.sop = 1'b1; bus.eop = 1'b1; bus.addr = 16'($urandom);
      end
      @(posedge clk); #1;
      bus.sink_valid = 1'b0; bus.sop = 1'b0; bus.eop = 1'b0;
      check("hold_valid", bus.source_valid, 1);
      check("hold_sink_ready", bus.sink_ready, 0);
      check("hold_outputs", {bus.class_result, bus.max_score, bus.margin, bus.tie}, word);
    end
    bus.source_ready = 1'b1;
    @(posedge clk); #1;
    bus.source_ready = 1'b0;
    check("valid_dropped", bus.source_valid, 0);
    check("ready_again", bus.sink_ready, 1);
  endtask

  initial begin
    bus.sink_valid = 1'b0; bus.sop = 1'b0; bus.eop = 1'b0;
    bus.index = '0; bus.addr = '0; bus.bleach = '0; bus.source_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_sink_ready", bus.sink_ready, 1);
    check("rst_source_valid", bus.source_valid, 0);
    check("rst_outputs", {bus.class_result, bus.max_score, bus.margin, bus.tie}, 0);
    rst = 1'b0;

    run_sample(3, 1, 0, -1, 7);
    run_sample(3, 1, 1, -1, 0);
    run_sample(4, 1, 3, -1, 2);
    run_sample(4, 1, 0, 2, 1);

    drive_beat(1, 1, 0, int'($urandom), 2);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    check("midsearch_rst_sink_ready", bus.sink_ready, 1);
    check("midsearch_rst_valid", bus.source_valid, 0);
    check("midsearch_rst_outputs", {bus.class_result, bus.max_score, bus.margin, bus.tie}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    run_sample(2, 0, 0, -1, 0);
    run_sample(1, 1, 0, -1, 1);

    run_sample(5, 1, 0, -1, 0);
    repeat (4) run_sample(60, 0, 0, -1, 0);

    for (int n = 0; n < 25; n++)
      run_sample($urandom_range(1, 8), $urandom_range(0, 4) != 0, $urandom_range(0, 3),
                 ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : -1,
                 $urandom_range(0, 4));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
